// File: rtl/rv32_branch_predictor.sv
// Bimodal branch predictor for an RV32 fetch stage.
// It holds a table of 2-bit saturating counters indexed by pc[INDEX_BITS+1:2].
// Lookups are registered and return one cycle after the PC is presented.
// The execute stage trains the table, and the block counts the mispredicts it reports.
module rv32_branch_predictor #(
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        lookup_valid_in,
    input  logic [31:0] lookup_pc_in,
    output logic        valid_out,
    output logic        predicted_taken_out,
    input  logic        update_valid_in,
    input  logic [31:0] update_pc_in,
    input  logic        update_taken_in,
    input  logic        update_mispredicted_in,
    output logic [31:0] mispredict_count_out
);

    localparam int unsigned NumEntries = 1 << INDEX_BITS;

    // Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
    logic [1:0] table_q [NumEntries];

    logic [INDEX_BITS-1:0] lookup_idx;
    logic [INDEX_BITS-1:0] update_idx;
    logic                  lookup_pred;
    logic [1:0]            update_ctr;
    logic [1:0]            update_ctr_d;

    logic        valid_q, valid_d;
    logic        taken_q, taken_d;
    logic [31:0] mispredict_count_q, mispredict_count_d;

    // The low two PC bits are ignored; instructions are word aligned.
    assign lookup_idx  = lookup_pc_in[INDEX_BITS+1:2];
    assign update_idx  = update_pc_in[INDEX_BITS+1:2];
    // The lookup reads the pre-update value; a same-cycle update is not bypassed.
    assign lookup_pred = table_q[lookup_idx][1];
    assign update_ctr  = table_q[update_idx];

    // Next lookup result: flush beats stall, and stall holds the last result.
    always_comb begin
        valid_d = valid_q;
        taken_d = taken_q;
        if (flush_in) begin
            valid_d = 1'b0;
            taken_d = 1'b0;
        end else if (!stall_in) begin
            valid_d = lookup_valid_in;
            taken_d = lookup_valid_in & lookup_pred;
        end
    end

    // Saturating increment or decrement of the counter being trained.
    always_comb begin
        update_ctr_d = update_ctr;
        if (update_taken_in) begin
            if (update_ctr != 2'b11) begin
                update_ctr_d = update_ctr + 2'b01;
            end
        end else begin
            if (update_ctr != 2'b00) begin
                update_ctr_d = update_ctr - 2'b01;
            end
        end
    end

    // Mispredict counter: it counts only qualified updates and wraps naturally at 2^32.
    always_comb begin
        mispredict_count_d = mispredict_count_q
                           + 32'(update_valid_in & update_mispredicted_in);
    end

    // State registers: reset overrides every lookup, update, stall and flush input.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NumEntries; i++) begin
                table_q[i] <= 2'b01;
            end
            valid_q            <= 1'b0;
            taken_q            <= 1'b0;
            mispredict_count_q <= 32'd0;
        end else begin
            valid_q            <= valid_d;
            taken_q            <= taken_d;
            mispredict_count_q <= mispredict_count_d;
            // Training ignores stall and flush.
            if (update_valid_in) begin
                table_q[update_idx] <= update_ctr_d;
            end
        end
    end

    assign valid_out            = valid_q;
    assign predicted_taken_out  = taken_q;
    assign mispredict_count_out = mispredict_count_q;

endmodule

// File: tb/tb_rv32_branch_predictor.sv
// Self-checking bench for rv32_branch_predictor at the default INDEX_BITS=6.
// A behavioural reference model pushes the expected outputs into a scoreboard queue.
// Each test task pops one entry per clock and compares it against the DUT outputs.
module tb_rv32_branch_predictor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall_in = 1'b0;
    logic        flush_in = 1'b0;
    logic        lookup_valid_in = 1'b0;
    logic [31:0] lookup_pc_in = '0;
    logic        valid_out;
    logic        predicted_taken_out;
    logic        update_valid_in = 1'b0;
    logic [31:0] update_pc_in = '0;
    logic        update_taken_in = 1'b0;
    logic        update_mispredicted_in = 1'b0;
    logic [31:0] mispredict_count_out;

    rv32_branch_predictor #(.INDEX_BITS(6)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .stall_in               (stall_in),
        .flush_in               (flush_in),
        .lookup_valid_in        (lookup_valid_in),
        .lookup_pc_in           (lookup_pc_in),
        .valid_out              (valid_out),
        .predicted_taken_out    (predicted_taken_out),
        .update_valid_in        (update_valid_in),
        .update_pc_in           (update_pc_in),
        .update_taken_in        (update_taken_in),
        .update_mispredicted_in (update_mispredicted_in),
        .mispredict_count_out   (mispredict_count_out)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [1:0]  mdl_tbl [64];
    logic        mdl_valid;
    logic        mdl_taken;
    logic [31:0] mdl_cnt;

    // Scoreboard entries are packed as {valid, taken, count}.
    logic [33:0] sb [$];
    logic [33:0] got;
    logic [33:0] exp_v;
    int          vectors = 0;
    int          errors = 0;

    // Drive one cycle of stimulus, push the model's expected outputs, then wait for the edge.
    task automatic step(input logic rst, input logic stall, input logic flush,
                        input logic lv, input logic [31:0] lpc,
                        input logic uv, input logic [31:0] upc,
                        input logic ut, input logic um);
        logic [1:0] c;
        reset = rst; stall_in = stall; flush_in = flush;
        lookup_valid_in = lv; lookup_pc_in = lpc;
        update_valid_in = uv; update_pc_in = upc;
        update_taken_in = ut; update_mispredicted_in = um;
        if (rst) begin
            for (int i = 0; i < 64; i++) mdl_tbl[i] = 2'b01;
            mdl_valid = 1'b0; mdl_taken = 1'b0; mdl_cnt = 32'd0;
        end else begin
            if (flush) begin
                mdl_valid = 1'b0; mdl_taken = 1'b0;
            end else if (!stall) begin
                mdl_valid = lv;
                mdl_taken = lv && (mdl_tbl[lpc[7:2]] >= 2'b10);
            end
            if (uv) begin
                c = mdl_tbl[upc[7:2]];
                if (ut && c != 2'b11) c = c + 2'b01;
                else if (!ut && c != 2'b00) c = c - 2'b01;
                mdl_tbl[upc[7:2]] = c;
                if (um) mdl_cnt = mdl_cnt + 32'd1;
            end
        end
        sb.push_back({mdl_valid, mdl_taken, mdl_cnt});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        got = {valid_out, predicted_taken_out, mispredict_count_out};
        exp_v = sb.pop_front(); vectors++;
        if (got !== exp_v || got !== 34'd0) begin
            errors++; $display("FAIL reset_state: got %h want %h", got, 34'd0);
        end
        step(0, 0, 0, 1, 32'h100, 0, 0, 0, 0);
        got = {valid_out, predicted_taken_out, mispredict_count_out};
        exp_v = sb.pop_front(); vectors++;
        if (got !== exp_v || got !== {2'b10, 32'd0}) begin
            errors++; $display("FAIL reset_lookup: got %h want %h", got, {2'b10, 32'd0});
        end
        // After reset, every PC must predict not-taken.
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 1, $urandom, 0, 0, 0, 0);
            got = {valid_out, predicted_taken_out, mispredict_count_out};
            exp_v = sb.pop_front(); vectors++;
            if (got !== exp_v || predicted_taken_out !== 1'b0) begin
                errors++; $display("FAIL reset_all_nt: got %h want %h", got, exp_v);
            end
        end
    endtask

    task automatic test_training();
        // Counter 01 -> 10 -> 11 -> 11 (saturates at 11).
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 1, 32'h100, 1, (i == 0));
            got = {valid_out, predicted_taken_out, mispredict_count_out};
            exp_v = sb.pop_front(); vectors++;
            if (got !== exp_v) begin
                errors++; $display("FAIL train_taken_upd: got %h want %h", got, exp_v);
            end
        end
        step(0, 0, 0, 1, 32'h100, 0, 0, 0, 0);
        got = {valid_out, predicted_taken_out, mispredict_count_out};
        exp_v = sb.pop_front(); vectors++;
        if (got !== exp_v || got !== {2'b11, 32'd1}) begin
            errors++; $display("FAIL train_taken: got %h want %h", got, {2'b11, 32'd1});
        end
        // One not-taken update: 11 -> 10, which still predicts taken.
        step(0, 0, 0, 0, 0, 1, 32'h100, 0, 1);
        step(0, 0, 0, 1, 32'h100, 0, 0, 0, 0);
        void'(sb.pop_front());
        got = {valid_out, predicted_taken_out, mispredict_count_out};
        exp_v = sb.pop_front(); vectors++;
        if (got !== exp_v || predicted_taken_out !== 1'b1) begin
            errors++; $display("FAIL train_weak_taken: got %h want %h", got, exp_v);
        end
        // Two more not-taken updates: 10 -> 01 -> 00, a third saturates at 00.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 32'h100, 0, 0);
        for (int i = 0; i < 3; i++) void'(sb.pop_front());
        step(0, 0, 0, 1, 32'h100, 0, 0, 0, 0);
        got = {valid_out, predicted_taken_out, mispredict_count_out};
        exp_v = sb.pop_front(); vectors++;
        if (got !== exp_v || got !== {2'b10, 32'd2}) begin
            errors++; $display("FAIL train_not_taken: got %h want %h", got, {2'b10, 32'd2});
        end
        // From 00, one taken update gives 01, which is still not-taken.
        step(0, 0, 0, 0, 0, 1, 32'h100, 1, 0);
        step(0, 0, 0, 1, 32'h100, 0, 0, 0, 0);
        void'(sb.pop_front());
        got = {valid_out, predicted_taken_out, mispredict_count_out};
        exp_v = sb.pop_front(); vectors++;
        if (got !== exp_v || predicted_taken_out !== 1'b0) begin
            errors++; $display("FAIL train_sat_low: got %h want %h", got, exp_v);
        end
    endtask

    task automatic test_aliasing();
        logic [31:0] pcs [3];
        logic        want [3];
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        void'(sb.pop_front());
        step(0, 0, 0, 0, 0, 1, 32'h100, 1, 0);
        step(0, 0, 0, 0, 0, 1, 32'h100, 1, 0);
        void'(sb.pop_front()); void'(sb.pop_front());
        pcs[0] = 32'h200; want[0] = 1'b1;
        pcs[1] = 32'h104; want[1] = 1'b0;
        pcs[2] = 32'h103; want[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, pcs[i], 0, 0, 0, 0);
            got = {valid_out, predicted_taken_out, mispredict_count_out};
            exp_v = sb.pop_front(); vectors++;
            if (got !== exp_v || predicted_taken_out !== want[i]) begin
                errors++; $display("FAIL alias pc=%h: got %h want %h", pcs[i], got, exp_v);
            end
        end
    endtask

    task automatic test_stall_flush();
        // Index 0 is trained taken (11) by test_aliasing, and index 1 is at 01.
        step(0, 0, 0, 1, 32'h100, 0, 0, 0, 0);
        got = {valid_out, predicted_taken_out, mispredict_count_out};
        exp_v = sb.pop_front(); vectors++;
        if (got !== exp_v || got !== {2'b11, 32'd0}) begin
            errors++; $display("FAIL sf_lookup: got %h want %h", got, {2'b11, 32'd0});
        end
        // A stall holds the outputs while the update to index 1 still trains it.
        step(0, 1, 0, 1, 32'h104, 1, 32'h104, 1, 0);
        got = {valid_out, predicted_taken_out, mispredict_count_out};
        exp_v = sb.pop_front(); vectors++;
        if (got !== exp_v || got !== {2'b11, 32'd0}) begin
            errors++; $display("FAIL sf_stall_hold: got %h want %h", got, {2'b11, 32'd0});
        end
        step(0, 1, 1, 1, 32'h100, 1, 32'h104, 1, 1);
        got = {valid_out, predicted_taken_out, mispredict_count_out};
        exp_v = sb.pop_front(); vectors++;
        if (got !== exp_v || got !== {2'b00, 32'd1}) begin
            errors++; $display("FAIL sf_flush: got %h want %h", got, {2'b00, 32'd1});
        end
        step(0, 0, 0, 1, 32'h104, 0, 0, 0, 0);
        got = {valid_out, predicted_taken_out, mispredict_count_out};
        exp_v = sb.pop_front(); vectors++;
        if (got !== exp_v || predicted_taken_out !== 1'b1) begin
            errors++; $display("FAIL sf_update_during_stall: got %h want %h", got, exp_v);
        end
        // A same-cycle lookup and update see the old counter (01), and the next lookup sees 10.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        void'(sb.pop_front());
        step(0, 0, 0, 1, 32'h100, 1, 32'h100, 1, 0);
        got = {valid_out, predicted_taken_out, mispredict_count_out};
        exp_v = sb.pop_front(); vectors++;
        if (got !== exp_v || got !== {2'b10, 32'd0}) begin
            errors++; $display("FAIL same_cycle_old: got %h want %h", got, {2'b10, 32'd0});
        end
        step(0, 0, 0, 1, 32'h100, 0, 0, 0, 0);
        got = {valid_out, predicted_taken_out, mispredict_count_out};
        exp_v = sb.pop_front(); vectors++;
        if (got !== exp_v || got !== {2'b11, 32'd0}) begin
            errors++; $display("FAIL same_cycle_new: got %h want %h", got, {2'b11, 32'd0});
        end
    endtask

    task automatic test_counter_wrap();
        // Backdoor: preload the count register to all ones through its next-state net.
        mdl_cnt = 32'hFFFF_FFFF;
        force dut.mispredict_count_d = 32'hFFFF_FFFF;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        release dut.mispredict_count_d;
        got = {valid_out, predicted_taken_out, mispredict_count_out};
        exp_v = sb.pop_front(); vectors++;
        if (got !== exp_v) begin
            errors++; $display("FAIL wrap_preload: got %h want %h", got, exp_v);
        end
        step(0, 0, 0, 0, 0, 0, 32'h100, 1, 1);
        got = {valid_out, predicted_taken_out, mispredict_count_out};
        exp_v = sb.pop_front(); vectors++;
        if (got !== exp_v || mispredict_count_out !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL wrap_ignore_invalid: got %h want %h", got, exp_v);
        end
        step(0, 0, 0, 0, 0, 1, 32'h100, 0, 1);
        got = {valid_out, predicted_taken_out, mispredict_count_out};
        exp_v = sb.pop_front(); vectors++;
        if (got !== exp_v || mispredict_count_out !== 32'd0) begin
            errors++; $display("FAIL wrap_to_zero: got %h want %h", got, exp_v);
        end
    endtask

    task automatic test_reset_mid();
        step(0, 0, 0, 0, 0, 1, 32'h108, 0, 1);
        step(0, 0, 0, 1, 32'h108, 0, 0, 0, 0);
        void'(sb.pop_front()); void'(sb.pop_front());
        // Reset together with a stall, a lookup and a mispredicted taken update.
        step(1, 1, 0, 1, 32'h100, 1, 32'h100, 1, 1);
        got = {valid_out, predicted_taken_out, mispredict_count_out};
        exp_v = sb.pop_front(); vectors++;
        if (got !== exp_v || got !== 34'd0) begin
            errors++; $display("FAIL reset_mid_outputs: got %h want %h", got, 34'd0);
        end
        step(0, 0, 0, 1, 32'h100, 0, 0, 0, 0);
        got = {valid_out, predicted_taken_out, mispredict_count_out};
        exp_v = sb.pop_front(); vectors++;
        if (got !== exp_v || got !== {2'b10, 32'd0}) begin
            errors++; $display("FAIL reset_mid_ctr: got %h want %h", got, {2'b10, 32'd0});
        end
        // The counter must be 01 (not 00), so one taken update flips it to taken.
        step(0, 0, 0, 0, 0, 1, 32'h100, 1, 0);
        step(0, 0, 0, 1, 32'h100, 0, 0, 0, 0);
        void'(sb.pop_front());
        got = {valid_out, predicted_taken_out, mispredict_count_out};
        exp_v = sb.pop_front(); vectors++;
        if (got !== exp_v || got !== {2'b11, 32'd0}) begin
            errors++; $display("FAIL reset_mid_is_01: got %h want %h", got, {2'b11, 32'd0});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] lpc, upc;
        for (int i = 0; i < 300; i++) begin
            lpc = {22'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 4'd0};
            upc = {22'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 4'd0};
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0), 1'($urandom), lpc,
                 1'($urandom), upc, 1'($urandom), 1'($urandom));
            got = {valid_out, predicted_taken_out, mispredict_count_out};
            exp_v = sb.pop_front(); vectors++;
            if (got !== exp_v) begin
                errors++; $display("FAIL random cycle %0d: got %h want %h", i, got, exp_v);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mdl_tbl[i] = 2'b01;
        mdl_valid = 1'b0; mdl_taken = 1'b0; mdl_cnt = 32'd0;
        @(negedge clk);
        test_reset();
        test_training();
        test_aliasing();
        test_stall_flush();
        test_counter_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
